adpll_lock_detect: RTL and testbench

Lock detector that consumes the ADPLL phase-detector error stream (5-bit magnitude plus sign, one sample per update strobe) and decides whether the loop is locked. It applies hysteresis: a long run of in-window samples declares lock, and a shorter run of out-of-window samples drops it. It also detects cycle slips, where the phase error wraps between saturated values of opposite sign, and keeps a saturating count of them. It sits directly downstream of the phase detector / loop filter in `adpll_top`, and its outputs go to status pins and the `out_sel` mux.

---
 rtl/adpll_lock_detect.sv | 126 ++++++++++++
 tb/tb_adpll_lock_detect.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/adpll_lock_detect.sv
// Lock detector for the ADPLL phase-error stream: hysteretic lock/unlock FSM
// plus cycle-slip detection with a saturating slip counter.
module adpll_lock_detect #(
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_CNT = 4,
  parameter int unsigned SLIP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              err_valid,
  input  logic [4:0]        err_mag,
  input  logic              err_sign,
  input  logic [4:0]        win,
  output logic              locked,
  output logic [1:0]        state,
  output logic              lock_chg,
  output logic              slip_pulse,
  output logic [SLIP_W-1:0] slip_cnt
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'b00,
    ACQUIRE  = 2'b01,
    LOCKED   = 2'b10,
    HOLD     = 2'b11
  } state_t;

  localparam logic [7:0] LOCK_N   = LOCK_CNT[7:0];
  localparam logic [7:0] UNLOCK_N = UNLOCK_CNT[7:0];
  localparam logic [4:0] SAT_MAG  = 5'd24;

  state_t     cur, nxt;
  logic [7:0] run_cnt, run_nxt;
  logic [7:0] miss_cnt, miss_nxt;
  logic       prev_sat, prev_sign;
  logic       chg_nxt;
  logic       sat, slip, in_win;
  logic [7:0] run_inc, miss_inc;

  // A slip sample is forced out-of-window even if the window covers it.
  assign sat      = err_mag >= SAT_MAG;
  assign slip     = err_valid && sat && prev_sat && (err_sign != prev_sign);
  assign in_win   = (err_mag <= win) && !slip;
  assign run_inc  = run_cnt + 8'd1;
  assign miss_inc = miss_cnt + 8'd1;

  always_comb begin
    nxt      = cur;
    run_nxt  = run_cnt;
    miss_nxt = miss_cnt;
    chg_nxt  = 1'b0;
    if (err_valid) begin
      unique case (cur)
        UNLOCKED: begin
          if (in_win) begin
            nxt     = ACQUIRE;
            run_nxt = 8'd1;
          end
        end
        ACQUIRE: begin
          if (in_win) begin
            if (run_inc == LOCK_N) begin
              nxt     = LOCKED;
              run_nxt = '0;
              chg_nxt = 1'b1;
            end else begin
              run_nxt = run_inc;
            end
          end else begin
            nxt     = UNLOCKED;
            run_nxt = '0;
          end
        end
        LOCKED: begin
          if (!in_win) begin
            nxt      = HOLD;
            miss_nxt = 8'd1;
          end
        end
        HOLD: begin
          if (in_win) begin
            nxt      = LOCKED;
            miss_nxt = '0;
          end else if (miss_inc == UNLOCK_N) begin
            nxt      = UNLOCKED;
            miss_nxt = '0;
            chg_nxt  = 1'b1;
          end else begin
            miss_nxt = miss_inc;
          end
        end
        default: nxt = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cur        <= UNLOCKED;
      run_cnt    <= '0;
      miss_cnt   <= '0;
      prev_sat   <= 1'b0;
      prev_sign  <= 1'b0;
      locked     <= 1'b0;
      lock_chg   <= 1'b0;
      slip_pulse <= 1'b0;
      slip_cnt   <= '0;
    end else begin
      cur        <= nxt;
      run_cnt    <= run_nxt;
      miss_cnt   <= miss_nxt;
      locked     <= nxt[1];
      lock_chg   <= chg_nxt;
      slip_pulse <= slip;
      if (err_valid) begin
        prev_sat  <= sat;
        prev_sign <= err_sign;
      end
      if (slip && (slip_cnt != '1)) slip_cnt <= slip_cnt + 1'b1;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_adpll_lock_detect.sv
// Directed bench for adpll_lock_detect with hand-computed expectations.
module tb_adpll_lock_detect;

  logic       clk = 1'b0;
  logic       rst, clr, err_valid, err_sign;
  logic [4:0] err_mag, win;
  logic       locked, lock_chg, slip_pulse;
  logic [1:0] state;
  logic [7:0] slip_cnt;

  int checks   = 0;
  int failures = 0;
  int pulses;

  adpll_lock_detect #(
    .LOCK_CNT(16),
    .UNLOCK_CNT(4),
    .SLIP_W(8)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .err_valid(err_valid), .err_mag(err_mag), .err_sign(err_sign), .win(win),
    .locked(locked), .state(state), .lock_chg(lock_chg),
    .slip_pulse(slip_pulse), .slip_cnt(slip_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One valid sample; outputs are observed 1 time unit after the edge.
  task automatic send(input logic [4:0] m, input logic s);
    err_valid = 1'b1;
    err_mag   = m;
    err_sign  = s;
    @(posedge clk);
    #1;
    err_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; err_valid = 1'b0; err_mag = '0; err_sign = 1'b0; win = 5'd5;
    do_reset();
    check("rst_state", state, 0);
    check("rst_locked", locked, 0);
    check("rst_chg", lock_chg, 0);
    check("rst_slip_pulse", slip_pulse, 0);
    check("rst_slip_cnt", slip_cnt, 0);

    // Acquire: 16 in-window samples
    pulses = 0;
    send(5'd3, 1'b0);
    check("acq_first_state", state, 1);
    for (int i = 2; i <= 15; i++) begin
      send(5'd3, 1'b0);
      if (state != 2'd1) check("acq_mid_state", state, 1);
      pulses += int'(lock_chg);
    end
    check("acq_no_early_chg", pulses, 0);
    send(5'd3, 1'b0);
    check("lock_state", state, 2);
    check("lock_locked", locked, 1);
    check("lock_chg_pulse", lock_chg, 1);
    @(posedge clk); #1;
    check("lock_chg_one_cycle", lock_chg, 0);
    check("idle_hold_state", state, 2);

    // 3 misses then recovery
    send(5'd9, 1'b0);
    check("hold_state", state, 3);
    check("hold_locked", locked, 1);
    send(5'd9, 1'b0);
    send(5'd9, 1'b0);
    check("hold3_state", state, 3);
    send(5'd3, 1'b0);
    check("relock_state", state, 2);
    check("relock_no_chg", lock_chg, 0);

    // 4 misses drop lock
    send(5'd9, 1'b0);
    send(5'd9, 1'b0);
    send(5'd9, 1'b0);
    check("miss3_state", state, 3);
    send(5'd9, 1'b0);
    check("unlock_state", state, 0);
    check("unlock_locked", locked, 0);
    check("unlock_chg", lock_chg, 1);

    // Abort acquire at run count 10
    for (int i = 0; i < 10; i++) send(5'd3, 1'b0);
    check("acq10_state", state, 1);
    send(5'd9, 1'b0);
    check("abort_state", state, 0);
    check("abort_chg", lock_chg, 0);
    for (int i = 0; i < 15; i++) send(5'd5, 1'b0);
    check("reacq15_state", state, 1);
    send(5'd5, 1'b0);
    check("reacq16_state", state, 2);

    // Slip detection with win=31
    do_reset();
    win = 5'd31;
    send(5'd31, 1'b0);
    check("sat_first_state", state, 1);
    check("sat_first_no_slip", slip_pulse, 0);
    send(5'd30, 1'b1);
    check("slip_pulse", slip_pulse, 1);
    check("slip_cnt1", slip_cnt, 1);
    check("slip_out_of_win", state, 0);
    send(5'd31, 1'b1);
    check("same_sign_no_slip", slip_pulse, 0);
    check("same_sign_state", state, 1);
    send(5'd31, 1'b1);
    check("same_sign_no_slip2", slip_pulse, 0);
    send(5'd23, 1'b0);
    check("mag23_no_slip", slip_pulse, 0);
    send(5'd31, 1'b0);
    check("after23_no_slip", slip_pulse, 0);
    send(5'd24, 1'b1);
    check("mag24_slip", slip_pulse, 1);
    check("slip_cnt2", slip_cnt, 2);
    @(posedge clk); #1;
    check("slip_pulse_one_cycle", slip_pulse, 0);

    // Saturation: 260 alternating saturated samples -> 259 slips
    do_reset();
    win = 5'd5;
    for (int i = 1; i <= 260; i++) begin
      send(5'd31, 1'(i % 2 == 0));
      if (i == 255) check("slip_cnt_254", slip_cnt, 254);
    end
    check("slip_cnt_sat", slip_cnt, 255);
    check("slip_pulse_at_sat", slip_pulse, 1);

    // clr in HOLD alongside an in-window sample
    do_reset();
    for (int i = 0; i < 16; i++) send(5'd3, 1'b0);
    check("clr_pre_locked", state, 2);
    send(5'd31, 1'b0);
    send(5'd31, 1'b1);
    check("clr_pre_hold", state, 3);
    check("clr_pre_slip_cnt", slip_cnt, 1);
    clr = 1'b1;
    send(5'd3, 1'b0);
    clr = 1'b0;
    check("clr_state", state, 0);
    check("clr_locked", locked, 0);
    check("clr_slip_cnt", slip_cnt, 0);
    check("clr_chg", lock_chg, 0);
    check("clr_slip_pulse", slip_pulse, 0);
    send(5'd31, 1'b0);
    check("clr_prev_cleared", slip_pulse, 0);
    send(5'd3, 1'b0);
    check("clr_run_restart", state, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
